// File: rtl/music_pkg.sv
// Shared types and helpers for the music playback path: state encoding,
// tempo select codes and the prescaler reload calculation.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] TEMPO_HALF = 2'd0;
  localparam logic [1:0] TEMPO_X1   = 2'd1;
  localparam logic [1:0] TEMPO_X2   = 2'd2;
  localparam logic [1:0] TEMPO_X4   = 2'd3;

  // Reload = cycles-per-step minus one; fast tempos clamp at zero so tiny
  // clock/step ratios never underflow into a huge count.
  function automatic logic [63:0] calc_reload(input logic [63:0] clk_hz,
                                               input logic [63:0] step_hz,
                                               input logic [1:0]  tempo);
    logic [63:0] w_period;
    logic [63:0] w_reload;
    w_period = clk_hz / step_hz;
    case (tempo)
      TEMPO_HALF: w_reload = (w_period << 1) - 64'd1;
      TEMPO_X1:   w_reload = w_period - 64'd1;
      TEMPO_X2:   w_reload = ((w_period >> 1) == 64'd0) ? '0 : (w_period >> 1) - 64'd1;
      default:    w_reload = ((w_period >> 2) == 64'd0) ? '0 : (w_period >> 2) - 64'd1;
    endcase
    return w_reload;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler with tempo-selected reload; o_tick is high in the
// cycle whose edge wraps the count, so the consumer acts on that same edge.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned STEP_HZ = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [1:0] i_tempo,
  output logic       o_tick
);
  import music_pkg::*;

  localparam logic [CNT_W-1:0] RL_HALF = CNT_W'(calc_reload(64'(CLK_HZ), 64'(STEP_HZ), TEMPO_HALF));
  localparam logic [CNT_W-1:0] RL_X1   = CNT_W'(calc_reload(64'(CLK_HZ), 64'(STEP_HZ), TEMPO_X1));
  localparam logic [CNT_W-1:0] RL_X2   = CNT_W'(calc_reload(64'(CLK_HZ), 64'(STEP_HZ), TEMPO_X2));
  localparam logic [CNT_W-1:0] RL_X4   = CNT_W'(calc_reload(64'(CLK_HZ), 64'(STEP_HZ), TEMPO_X4));

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_reload;

  always_comb begin
    w_reload = RL_X1;
    case (i_tempo)
      TEMPO_HALF: w_reload = RL_HALF;
      TEMPO_X1:   w_reload = RL_X1;
      TEMPO_X2:   w_reload = RL_X2;
      default:    w_reload = RL_X4;
    endcase
  end

  // >= rather than == so a mid-count switch to a shorter reload fires at once.
  assign o_tick = i_en & (r_cnt >= w_reload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_seq_ctrl.sv
// Playback controller for the tone-ROM player: IDLE/PLAY/DONE sequencing,
// note address counter and step/wrap strobes for the tone divider.
module music_seq_ctrl #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned STEP_HZ   = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LAST_ADDR = 420,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        tempo,
  output logic [ADDR_W-1:0] addr,
  output logic              step_tick,
  output logic              wrap_pulse,
  output logic              playing,
  output logic              done
);
  import music_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nx;
  logic              r_step;
  logic              w_step_nx;
  logic              r_wrap;
  logic              w_wrap_nx;
  logic              w_pre_en;
  logic              w_pre_clr;
  logic              w_pre_tick;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(STEP_HZ),
    .CNT_W  (CNT_W)
  ) u_prescaler (
    .clk    (in_clk),
    .rst_n  (rst),
    .i_en   (w_pre_en),
    .i_clr  (w_pre_clr),
    .i_tempo(tempo),
    .o_tick (w_pre_tick)
  );

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_step  <= w_step_nx;
      r_wrap  <= w_wrap_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_step_nx  = 1'b0;
    w_wrap_nx  = 1'b0;
    w_pre_en   = 1'b0;
    w_pre_clr  = 1'b0;
    if (stop) begin
      w_state_nx = IDLE;
      w_addr_nx  = '0;
      w_pre_clr  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_addr_nx = '0;
          w_pre_clr = 1'b1;
          if (start) w_state_nx = PLAY;
        end
        PLAY: begin
          if (start) begin
            w_addr_nx = '0;
            w_pre_clr = 1'b1;
          end else if (!pause) begin
            w_pre_en = 1'b1;
            if (w_pre_tick) begin
              if (r_addr < LAST) begin
                w_addr_nx = r_addr + ADDR_W'(1);
                w_step_nx = 1'b1;
              end else if (loop_en) begin
                w_addr_nx = '0;
                w_step_nx = 1'b1;
                w_wrap_nx = 1'b1;
              end else begin
                w_state_nx = DONE;
              end
            end
          end
        end
        DONE: begin
          w_pre_clr = 1'b1;
          if (start) begin
            w_state_nx = PLAY;
            w_addr_nx  = '0;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_addr_nx  = '0;
          w_pre_clr  = 1'b1;
        end
      endcase
    end
  end

  assign addr       = r_addr;
  assign step_tick  = r_step;
  assign wrap_pulse = r_wrap;
  assign playing    = (r_state == PLAY);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed plus randomized bench for music_seq_ctrl against a per-cycle
// behavioural model of the playback rules (CLK_HZ=64, STEP_HZ=4, LAST_ADDR=5).
module tb_music_seq_ctrl;

  localparam int LAST = 5;

  logic       in_clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b1;
  logic [1:0] tempo = 2'd1;
  logic [3:0] addr;
  logic       step_tick;
  logic       wrap_pulse;
  logic       playing;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  // model: mode 0 = idle, 1 = playing, 2 = finished
  int m_mode = 0;
  int m_elapsed = 0;
  int m_addr = 0;
  int m_tick = 0;
  int m_wrap = 0;

  music_seq_ctrl #(
    .CLK_HZ   (64),
    .STEP_HZ  (4),
    .ADDR_W   (4),
    .LAST_ADDR(LAST),
    .CNT_W    (8)
  ) dut (
    .in_clk    (in_clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .tempo     (tempo),
    .addr      (addr),
    .step_tick (step_tick),
    .wrap_pulse(wrap_pulse),
    .playing   (playing),
    .done      (done)
  );

  always #5 in_clk = ~in_clk;

  // cycles per note step: 64/4 = 16 at x1, scaled by tempo
  function automatic int step_period(input logic [1:0] t);
    case (t)
      2'd0:    return 32;
      2'd1:    return 16;
      2'd2:    return 8;
      default: return 4;
    endcase
  endfunction

  task automatic model_clear();
    m_mode = 0; m_elapsed = 0; m_addr = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_wrap = 0;
    if (!rst) begin
      model_clear();
    end else if (stop) begin
      m_mode = 0; m_addr = 0; m_elapsed = 0;
    end else if (m_mode == 0) begin
      m_addr = 0; m_elapsed = 0;
      if (start) m_mode = 1;
    end else if (m_mode == 2) begin
      m_elapsed = 0;
      if (start) begin m_mode = 1; m_addr = 0; end
    end else if (start) begin
      m_addr = 0; m_elapsed = 0;
    end else if (!pause) begin
      // elapsed counts cycles already spent on the current note
      if (m_elapsed + 1 >= step_period(tempo)) begin
        m_elapsed = 0;
        if (m_addr < LAST) begin
          m_addr++; m_tick = 1;
        end else if (loop_en) begin
          m_addr = 0; m_tick = 1; m_wrap = 1;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("addr",       32'(addr),       32'(m_addr));
    chk("step_tick",  32'(step_tick),  32'(m_tick));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    chk("playing",    32'(playing),    32'(m_mode == 1));
    chk("done",       32'(done),       32'(m_mode == 2));
  endtask

  task automatic tick1();
    @(posedge in_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick1(); start = 1'b0;
  endtask

  initial begin
    // reset state
    run(3);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    rst = 1'b1;
    run(5);

    // x1 looping playback through one full wrap
    pulse_start();
    run(15);
    chk("first_step_quiet", 32'(step_tick), 32'd0);
    tick1();
    chk("first_step", 32'(step_tick), 32'd1);
    chk("first_addr", 32'(addr), 32'd1);
    run(90);

    // tempo periods
    tempo = 2'd0; pulse_start(); run(70);
    tempo = 2'd2; pulse_start(); run(20);
    tempo = 2'd3; pulse_start(); run(10);

    // switch x0.5 -> x4 with elapsed count at 20
    tempo = 2'd0; pulse_start(); run(20);
    tempo = 2'd3; tick1();
    chk("tempo_switch_step", 32'(step_tick), 32'd1);
    run(3);
    chk("x4_quiet", 32'(step_tick), 32'd0);
    tick1();
    chk("x4_step", 32'(step_tick), 32'd1);

    // one-shot
    tempo = 2'd1; loop_en = 1'b0; pulse_start(); run(96);
    chk("oneshot_done", 32'(done), 32'd1);
    chk("oneshot_addr", 32'(addr), 32'(LAST));
    run(20);
    pulse_start();
    chk("restart_addr", 32'(addr), 32'd0);
    run(16);
    chk("restart_step", 32'(step_tick), 32'd1);

    // pause at addr 2, elapsed 7
    loop_en = 1'b1; pulse_start(); run(39);
    pause = 1'b1; run(40);
    pause = 1'b0; run(8);
    tick1();
    chk("pause_resume_step", 32'(step_tick), 32'd1);
    chk("pause_resume_addr", 32'(addr), 32'd3);

    // start+stop together, then restart while paused
    pulse_start(); run(10);
    start = 1'b1; stop = 1'b1; tick1(); start = 1'b0; stop = 1'b0;
    chk("startstop_playing", 32'(playing), 32'd0);
    pulse_start(); run(48);
    pause = 1'b1; run(5);
    start = 1'b1; tick1(); start = 1'b0;
    chk("paused_restart_addr", 32'(addr), 32'd0);
    pause = 1'b0; run(16);
    chk("paused_restart_step", 32'(step_tick), 32'd1);

    // asynchronous reset mid-play
    pulse_start(); run(64);
    #3 rst = 1'b0;
    #1 model_clear();
    check_all();
    run(3);
    rst = 1'b1;
    run(100);

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 199) < 1);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) loop_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) tempo = 2'($urandom_range(0, 3));
      tick1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
